// File: rtl/shift_issue.sv
// shift_issue: issue queue feeding a barrel shifter with decoded RV32I shifts.
//
// Only the six shift instructions are recognised and queued. An offer is
// accepted whenever the queue is not full. An accepted instruction that is
// not one of the six shifts is dropped, and `illegal` pulses on the next cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready = not full)
//   instr                 raw RV32I instruction word
//   rs1_data, rs2_data    register-file operands
//   out_valid / out_ready downstream handshake (out_valid = not empty)
//   a, shamt, shift_type  head entry: operand, amount, {instr[30], instr[14]}
//   rd                    head entry destination register
//   illegal               one-cycle pulse after a dropped non-shift
//   count                 current occupancy
// `type` is a reserved SystemVerilog keyword, so the type output is named
// shift_type.
module shift_issue #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [31:0]              rs1_data,
  input  logic [31:0]              rs2_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              a,
  output logic [4:0]               shamt,
  output logic [1:0]               shift_type,
  output logic [4:0]               rd,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   r_a     [DEPTH];
  logic [4:0]    r_shamt [DEPTH];
  logic [1:0]    r_type  [DEPTH];
  logic [4:0]    r_rd    [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_illegal;

  logic [6:0]    w_opcode;
  logic [2:0]    w_funct3;
  logic [6:0]    w_funct7;
  logic          w_is_imm;
  logic          w_is_reg;
  logic          w_funct_ok;
  logic          w_legal;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_shamt_in;
  logic          w_unused;

  assign w_opcode   = instr[6:0];
  assign w_funct3   = instr[14:12];
  assign w_funct7   = instr[31:25];
  assign w_is_imm   = (w_opcode == 7'b0010011);
  assign w_is_reg   = (w_opcode == 7'b0110011);
  // SLL needs funct7 zero; SRL/SRA share funct3 101 and differ only in funct7.
  assign w_funct_ok = ((w_funct3 == 3'b001) && (w_funct7 == 7'b0000000)) ||
                      ((w_funct3 == 3'b101) &&
                       ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000)));
  assign w_legal    = (w_is_imm || w_is_reg) && w_funct_ok;

  assign in_ready   = (r_count != FULL_COUNT);
  assign out_valid  = (r_count != {CW{1'b0}});
  assign w_accept   = in_valid && in_ready;
  assign w_push     = w_accept && w_legal;
  assign w_pop      = out_valid && out_ready;
  assign w_shamt_in = w_is_reg ? rs2_data[4:0] : instr[24:20];

  // rs1 field and the upper bits of rs2_data play no part in a shift issue.
  assign w_unused   = &{1'b0, instr[19:15], rs2_data[31:5]};

  assign count      = r_count;
  assign illegal    = r_illegal;

  // Queue storage: capture operands of a recognised shift at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_a[i]     <= 32'd0;
        r_shamt[i] <= 5'd0;
        r_type[i]  <= 2'd0;
        r_rd[i]    <= 5'd0;
      end
    end else if (w_push) begin
      r_a[r_wptr]     <= rs1_data;
      r_shamt[r_wptr] <= w_shamt_in;
      r_type[r_wptr]  <= {instr[30], instr[14]};
      r_rd[r_wptr]    <= instr[11:7];
    end else begin
      r_a[r_wptr]     <= r_a[r_wptr];
    end
  end

  // Pointers, occupancy and the illegal pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= {AW{1'b0}};
      r_rptr    <= {AW{1'b0}};
      r_count   <= {CW{1'b0}};
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      // DEPTH is a power of two, so natural overflow wraps the pointers.
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation: zeros when empty so nothing stale leaks downstream.
  always_comb begin
    a          = 32'd0;
    shamt      = 5'd0;
    shift_type = 2'd0;
    rd         = 5'd0;
    if (out_valid) begin
      a          = r_a[r_rptr];
      shamt      = r_shamt[r_rptr];
      shift_type = r_type[r_rptr];
      rd         = r_rd[r_rptr];
    end else begin
      a          = 32'd0;
      shamt      = 5'd0;
      shift_type = 2'd0;
      rd         = 5'd0;
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
module tb_shift_issue;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [1:0]  shift_type;
  logic [4:0]  rd;
  logic        illegal;
  logic [$clog2(DEPTH):0] count;

  shift_issue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a          (a),
    .shamt      (shamt),
    .shift_type (shift_type),
    .rd         (rd),
    .illegal    (illegal),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  sh;
    logic [1:0]  ty;
    logic [4:0]  rd;
  } ent_t;

  ent_t mq[$];
  logic m_ill = 1'b0;
  logic [4:0] popped[$];

  localparam logic [31:0] SHIFT_MASK = 32'hFE00707F;
  localparam logic [31:0] SHIFT_PATS [6] = '{32'h00001013, 32'h00005013, 32'h40005013,
                                              32'h00001033, 32'h00005033, 32'h40005033};

  function automatic bit m_legal(input logic [31:0] w);
    bit hit = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if ((w & SHIFT_MASK) == SHIFT_PATS[k]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic ent_t m_entry(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
    ent_t e;
    e.a  = r1;
    e.sh = w[5] ? r2[4:0] : w[24:20];
    e.ty = {w[30], w[14]};
    e.rd = w[11:7];
    return e;
  endfunction

  // Model state follows the queue rules from the inputs alone.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ill <= 1'b0;
    end else begin
      int sz;
      sz = mq.size();
      m_ill <= in_valid && (sz != DEPTH) && !m_legal(instr);
      if (out_ready && sz != 0) void'(mq.pop_front());
      if (in_valid && sz != DEPTH && m_legal(instr)) mq.push_back(m_entry(instr, rs1_data, rs2_data));
    end
  end

  // Every-cycle comparison of all outputs against the model.
  ent_t cmp_h;
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_h = (mq.size() != 0) ? mq[0] : '0;
      chk("in_ready",  32'(in_ready),   32'(mq.size() != DEPTH));
      chk("out_valid", 32'(out_valid),  32'(mq.size() != 0));
      chk("count",     32'(count),      32'(mq.size()));
      chk("a",         a,               cmp_h.a);
      chk("shamt",     32'(shamt),      32'(cmp_h.sh));
      chk("type",      32'(shift_type), 32'(cmp_h.ty));
      chk("rd",        32'(rd),         32'(cmp_h.rd));
      chk("illegal",   32'(illegal),    32'(m_ill));
      if (out_valid && out_ready) popped.push_back(rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Holds an offer until accepted; returns just after the accepting edge.
  task automatic offer(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
    bit acc = 1'b0;
    instr = w; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    if (!acc) begin
      errors++;
      $display("FAIL offer_timeout actual=not_accepted required=accepted instr=%h", w);
    end
    in_valid = 1'b0;
  endtask

  localparam logic [31:0] I_SRAI = 32'h40435293;  // srai x5,x6,4
  localparam logic [31:0] I_SLL  = 32'h002093B3;  // sll  x7,x1,x2
  localparam logic [31:0] I_SRLI = 32'h00715093;  // srli x1,x2,7
  localparam logic [31:0] I_SRA  = 32'h405251B3;  // sra  x3,x4,x5
  localparam logic [31:0] I_SLLI = 32'h01F51493;  // slli x9,x10,31
  localparam logic [31:0] I_ADDI = 32'h00100093;  // addi x1,x0,1

  initial begin
    in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_a",         a,              32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step();

    // SRAI x5,x6,4 from empty.
    offer(I_SRAI, 32'h80000000, 32'h0);
    @(negedge clk);
    chk("srai_valid", 32'(out_valid),  32'd1);
    chk("srai_a",     a,               32'h80000000);
    chk("srai_shamt", 32'(shamt),      32'd4);
    chk("srai_type",  32'(shift_type), 32'd3);
    chk("srai_rd",    32'(rd),         32'd5);
    chk("srai_count", 32'(count),      32'd1);
    step();
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // SLL: shamt from rs2_data low bits only.
    offer(I_SLL, 32'h12345678, 32'hFFFFFFE3);
    @(negedge clk);
    chk("sll_shamt", 32'(shamt),      32'd3);
    chk("sll_type",  32'(shift_type), 32'd0);
    chk("sll_rd",    32'(rd),         32'd7);
    step();
    out_ready = 1'b1; step(); out_ready = 1'b0;
    step();

    // Three pushes into a DEPTH=2 queue with out_ready low.
    popped.delete();
    offer(I_SRLI, 32'h0000_1111, 32'h0);
    offer(I_SRA,  32'h0000_2222, 32'h0000_0021);
    fork
      offer(I_SLLI, 32'h0000_3333, 32'h0);
      begin
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count",    32'(count),    32'd2);
        step();
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    chk("order_n",  32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("order_0", 32'(popped[0]), 32'd1);
      chk("order_1", 32'(popped[1]), 32'd3);
      chk("order_2", 32'(popped[2]), 32'd9);
    end

    // count=1, simultaneous push/pop eight times across pointer wrap.
    offer(32'h00001013 | (32'd10 << 7) | (32'd1 << 20), 32'hA000_0000, 32'h0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr    = 32'h00001013 | (32'(i + 11) << 7) | (32'(i + 2) << 20);
      rs1_data = 32'hB000_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("wrap_count", 32'(count), 32'd1);
    chk("wrap_rd",    32'(rd),    32'd18);
    step();

    // ADDI is dropped with a one-cycle illegal pulse.
    offer(I_ADDI, 32'h0, 32'h0);
    @(negedge clk);
    chk("addi_illegal", 32'(illegal),   32'd1);
    chk("addi_count",   32'(count),     32'd1);
    chk("addi_valid",   32'(out_valid), 32'd1);
    @(negedge clk);
    chk("addi_pulse_end", 32'(illegal), 32'd0);
    step();
    out_ready = 1'b1; step(); step(); out_ready = 1'b0;

    // Asynchronous reset with a full queue.
    offer(I_SRLI, 32'h5555_0000, 32'h0);
    offer(I_SRA,  32'h6666_0000, 32'h0000_0004);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",    32'(out_valid), 32'd0);
    chk("arst_count",    32'(count),     32'd0);
    chk("arst_in_ready", 32'(in_ready),  32'd1);
    chk("arst_a",        a,              32'd0);
    chk("arst_rd",       32'(rd),        32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    offer(I_SRAI, 32'h8000_0000, 32'h0);
    @(negedge clk);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_a",     a,          32'h8000_0000);
    step();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_issue.md
SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning queue entries (power of two, minimum 2).
REQ-002 The block SHALL have port clk  input  1  the only clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid  input  1  upstream offers an instruction.
REQ-005 The block SHALL have port in_ready  output  1  the block accepts the offer this cycle.
REQ-006 The block SHALL have port instr  input  32  raw RV32I instruction word.
REQ-007 The block SHALL have port rs1_data  input  32  register-file value of rs1.
REQ-008 The block SHALL have port rs2_data  input  32  register-file value of rs2.
REQ-009 The block SHALL have port out_valid  output  1  head entry is valid for the shifter.
REQ-010 The block SHALL have port out_ready  input  1  downstream shifter/writeback consumes the head.
REQ-011 The block SHALL have port a  output  32  shifter operand.
REQ-012 The block SHALL have port shamt  output  5  shift amount.
REQ-013 The block SHALL have port type  output  2  {instr[30], instr[14]}: 00 SLL, 01 SRL, 11 SRA.
REQ-014 The block SHALL have port rd  output  5  destination register of the head entry.
REQ-015 The block SHALL have port illegal  output  1  one-cycle pulse for a dropped non-shift instruction.
REQ-016 The block SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Handshake: transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-018 Recognised shifts: opcode 0010011 with funct3 001/funct7 0000000 (SLLI), funct3 101/funct7 0000000 (SRLI), funct3 101/funct7 0100000 (SRAI); opcode 0110011 with the same funct3/funct7 pairs (SLL, SRL, SRA).
REQ-019 Immediate forms: shamt = instr[24:20]; register forms: shamt = rs2_data[4:0] (upper bits ignored).
REQ-020 Each entry SHALL store a = rs1_data, shamt, type = {instr[30], instr[14]}, rd = instr[11:7], captured at the accept edge.
REQ-021 in_ready SHALL equal (count != DEPTH); no pop-through when full, even if out_ready is high.
REQ-022 An accepted non-recognised instruction SHALL NOT be enqueued, count unchanged, illegal high for exactly the following cycle.
REQ-023 out_valid SHALL equal (count != 0); no empty bypass: accept-to-out_valid latency exactly 1 cycle.
REQ-024 While out_valid is high and out_ready low, a/shamt/type/rd SHALL hold stable.
REQ-025 When empty, a/shamt/type/rd SHALL be driven to zero.
REQ-026 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, order preserved.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; strict FIFO order across wrap.
REQ-028 in_valid with in_ready low SHALL have no effect; upstream holds its offer.

Reset
REQ-029 rst_n low SHALL immediately clear pointers, count = 0, out_valid = 0, illegal = 0, a/shamt/type/rd = 0, in_ready = 1.
REQ-030 Reset mid-operation SHALL discard all queued entries; first edge after deassertion behaves as from empty.

Verification
REQ-031 Empty, accept SRAI x5,x6,4 (instr 0x40435293), rs1_data=0x80000000 -> next cycle out_valid=1, a=0x80000000, shamt=4, type=11, rd=5, count=1.
REQ-032 Accept SLL with rs2_data=0xFFFFFFE3 -> shamt=3, type=00.
REQ-033 out_ready=0, push three shifts (DEPTH=2) -> third sees in_ready=0, count=2; release out_ready -> entries appear in push order, third accepted after first pop.
REQ-034 Accept ADDI (0x00100093) -> illegal=1 for one cycle, count unchanged, out_valid unchanged.
REQ-035 count=1, push and pop same cycle, repeated 8 times -> count stays 1, pointer wrap verified, order preserved.
REQ-036 count=2, assert rst_n=0 asynchronously mid-cycle -> out_valid=0, count=0, outputs zero before next edge.
